// File: rtl/dcache_direct_if.sv
// +----------------------------------------------------------------------+
// | dcache_direct_if : processor and memory buses of the direct cache     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface dcache_direct_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dcache_direct.sv
// +----------------------------------------------------------------------+
// | dcache_direct : 8-line x 4-word direct-mapped write-back cache        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dcache_direct (
  input  wire logic        clk,
  input  wire logic        rst,
  dcache_direct_if.slave   bus
);

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    valid_q;
  logic [7:0]    dirty_q;
  logic [24:0]   tag_q  [8];
  logic [127:0]  data_q [8];

  logic [1:0]    w_off;
  logic [2:0]    w_idx;
  logic [24:0]   w_tag;
  logic          w_req;
  logic          w_hit;
  logic          w_wr_hit;
  logic          w_fill;

  assign w_off    = bus.proc_addr[1:0];
  assign w_idx    = bus.proc_addr[4:2];
  assign w_tag    = bus.proc_addr[29:5];
  assign w_req    = bus.proc_read | bus.proc_write;
  assign w_hit    = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_wr_hit = (state_q == COMPARE) && bus.proc_write && w_hit;
  assign w_fill   = (state_q == ALLOCATE) && bus.mem_ready;

  // The addressed word is always presented; it only matters on a read hit.
  assign bus.proc_rdata = data_q[w_idx][{w_off, 5'b0} +: 32];
  assign bus.mem_wdata  = data_q[w_idx];

  always_comb begin
    state_d        = state_q;
    bus.proc_stall = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = {w_tag, w_idx};
    case (state_q)
      COMPARE: begin
        if (w_req && !w_hit) begin
          bus.proc_stall = 1'b1;
          state_d = (valid_q[w_idx] && dirty_q[w_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {tag_q[w_idx], w_idx};
        if (bus.mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        if (bus.mem_ready) state_d = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  // Tag and data arrays are deliberately left out of reset; valid gates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COMPARE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_wr_hit) begin
        data_q[w_idx][{w_off, 5'b0} +: 32] <= bus.proc_wdata;
        dirty_q[w_idx] <= 1'b1;
      end
      if (w_fill) begin
        data_q[w_idx]  <= bus.mem_rdata;
        tag_q[w_idx]   <= w_tag;
        valid_q[w_idx] <= 1'b1;
        dirty_q[w_idx] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_direct.sv
// +----------------------------------------------------------------------+
// | tb_dcache_direct : directed table plus random traffic vs cache model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dcache_direct;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_direct_if bus();
  dcache_direct dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Backing memory: lines never written back hold an address-derived pattern.
  logic [127:0] mem [logic [27:0]];

  function automatic logic [127:0] line_of(input logic [27:0] la);
    if (mem.exists(la)) return mem[la];
    return {la, 4'hB, la, 4'hA, la, 4'h9, la, 4'h8};
  endfunction

  // Reference model: what each cache slot should hold.
  bit          mv [8];
  bit          md [8];
  logic [24:0] mt [8];
  logic [31:0] mdat [8][4];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  // One processor request, serviced by the bench memory with a fixed latency.
  task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, input int lat,
                        output int stalls, output bit wbs, output logic [27:0] wba,
                        output logic [127:0] wbd, output bit rds,
                        output logic [27:0] rda, output logic [31:0] rdat);
    logic [2:0]   idx;
    logic [24:0]  tg;
    logic [1:0]   off;
    bit           hit, ewb, done, both, chg;
    int           cnt, exp_stall;
    logic [127:0] eline;
    idx = a[4:2];
    tg  = a[29:5];
    off = a[1:0];
    hit = mv[idx] && (mt[idx] == tg);
    ewb = !hit && mv[idx] && md[idx];
    exp_stall = hit ? 0 : 1 + (ewb ? lat : 0) + lat;
    eline = {mdat[idx][3], mdat[idx][2], mdat[idx][1], mdat[idx][0]};

    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = wd;
    stalls = 0; wbs = 0; rds = 0; wba = '0; wbd = '0; rda = '0; rdat = '0;
    done = 0; both = 0; chg = 0; cnt = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (!bus.proc_stall) begin
        done = 1;
        rdat = bus.proc_rdata;
      end else begin
        stalls++;
        if (bus.mem_read && bus.mem_write) both = 1;
        if (bus.mem_write) begin
          wbs = 1;
          wba = bus.mem_addr;
          wbd = bus.mem_wdata;
        end
        if (bus.mem_read) begin
          if (rds && rda !== bus.mem_addr) chg = 1;
          rds = 1;
          rda = bus.mem_addr;
        end
        if (bus.mem_read || bus.mem_write) begin
          cnt++;
          if (cnt == lat) begin
            bus.mem_ready = 1'b1;
            if (bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = line_of(bus.mem_addr);
            cnt = 0;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
    end
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: request %h never completed", a);
    end

    chk("stall_cycles", 128'(stalls), 128'(exp_stall));
    chk("writeback_seen", 128'(wbs), 128'(ewb));
    if (ewb) begin
      chk("writeback_addr", 128'(wba), 128'({mt[idx], idx}));
      chk("writeback_data", wbd, eline);
    end
    chk("refill_seen", 128'(rds), 128'(!hit));
    if (!hit) chk("refill_addr", 128'(rda), 128'({tg, idx}));
    chk("rd_wr_both_high", 128'(both), 128'(0));
    chk("refill_addr_stable", 128'(chg), 128'(0));

    if (!hit) begin
      eline = line_of({tg, idx});
      for (int w = 0; w < 4; w++) mdat[idx][w] = eline[32*w +: 32];
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tg;
    end
    if (wr) begin
      mdat[idx][off] = wd;
      md[idx] = 1'b1;
    end else begin
      chk("read_data", 128'(rdat), 128'(mdat[idx][off]));
    end
  endtask

  typedef struct {
    bit          wr;
    logic [29:0] a;
    logic [31:0] wd;
    int          lat;
    int          e_stall;
    bit          e_wb;
    logic [27:0] e_wba;
    bit          e_rd;
    logic [27:0] e_rda;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t vt [5];

  initial begin
    int           st;
    bit           wbs, rds;
    logic [27:0]  wba, rda;
    logic [127:0] wbd;
    logic [31:0]  rdat;

    vt[0] = '{1'b0, 30'h5,  32'h0,        3, 4, 1'b0, 28'h0, 1'b1, 28'h1, 32'hDEADBEEF};
    vt[1] = '{1'b1, 30'h5,  32'h12345678, 3, 0, 1'b0, 28'h0, 1'b0, 28'h0, 32'h0};
    vt[2] = '{1'b0, 30'h5,  32'h0,        3, 0, 1'b0, 28'h0, 1'b0, 28'h0, 32'h12345678};
    vt[3] = '{1'b0, 30'h25, 32'h0,        3, 7, 1'b1, 28'h1, 1'b1, 28'h9, 32'h00000099};
    vt[4] = '{1'b0, 30'h5,  32'h0,        3, 4, 1'b0, 28'h0, 1'b1, 28'h1, 32'h12345678};

    mem[28'h1] = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    model_reset();

    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 128'(bus.proc_stall), 128'(0));
    chk("reset_mem_read", 128'(bus.mem_read), 128'(0));
    chk("reset_mem_write", 128'(bus.mem_write), 128'(0));

    // A stray ready pulse while idle must not disturb anything.
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_mem_read", 128'(bus.mem_read), 128'(0));
    chk("idle_ready_stall", 128'(bus.proc_stall), 128'(0));
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++) begin
      access(!vt[k].wr, vt[k].wr, vt[k].a, vt[k].wd, vt[k].lat,
             st, wbs, wba, wbd, rds, rda, rdat);
      chk($sformatf("vec%0d_stall", k), 128'(st), 128'(vt[k].e_stall));
      chk($sformatf("vec%0d_wb", k), 128'(wbs), 128'(vt[k].e_wb));
      if (vt[k].e_wb) chk($sformatf("vec%0d_wba", k), 128'(wba), 128'(vt[k].e_wba));
      chk($sformatf("vec%0d_rd", k), 128'(rds), 128'(vt[k].e_rd));
      if (vt[k].e_rd) chk($sformatf("vec%0d_rda", k), 128'(rda), 128'(vt[k].e_rda));
      if (!vt[k].wr) chk($sformatf("vec%0d_rdata", k), 128'(rdat), 128'(vt[k].e_rdat));
      if (k == 3) chk("vec3_wb_word1", 128'(wbd[63:32]), 128'(32'h12345678));
    end

    // Reset in the middle of a writeback drops both the transfer and the dirty data.
    access(1'b0, 1'b1, 30'h5, 32'hCAFEF00D, 3, st, wbs, wba, wbd, rds, rda, rdat);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h25;
    @(negedge clk);
    chk("rstwb_compare_stall", 128'(bus.proc_stall), 128'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstwb_in_writeback", 128'(bus.mem_write), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.proc_read = 1'b0;
    @(negedge clk);
    chk("rstwb_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rstwb_mem_read", 128'(bus.mem_read), 128'(0));
    chk("rstwb_stall", 128'(bus.proc_stall), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 30'h5, 32'h0, 2, st, wbs, wba, wbd, rds, rda, rdat);
    chk("post_reset_miss", 128'(st), 128'(3));
    chk("post_reset_data", 128'(rdat), 128'(32'h12345678));

    // Memory holds off ready for 50 allocate cycles.
    access(1'b1, 1'b0, 30'h10, 32'h0, 51, st, wbs, wba, wbd, rds, rda, rdat);
    chk("slow_mem_stall", 128'(st), 128'(52));
    chk("slow_mem_rda", 128'(rda), 128'(28'h4));

    for (int n = 0; n < 300; n++) begin
      logic [29:0] a;
      int          kind;
      a        = '0;
      a[29:5]  = 25'($urandom_range(0, 3));
      a[4:0]   = 5'($urandom);
      kind     = $urandom_range(0, 3);
      access(kind != 2, kind >= 2, a, $urandom, $urandom_range(1, 4),
             st, wbs, wba, wbd, rds, rda, rdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_direct.md
DCACHE_DIRECT -- requirements
Module: dcache_direct

Interface
REQ-001 The block SHALL have no parameters; geometry SHALL be fixed at 8 lines x 4 words (128-bit line), direct-mapped, write-back, write-allocate.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 proc_read  input  1  processor read request.
REQ-005 proc_write  input  1  processor write request.
REQ-006 proc_addr  input  30  word address; offset [1:0], index [4:2], tag [29:5].
REQ-007 proc_wdata  input  32  write data, stored unmodified with no byte swapping.
REQ-008 proc_stall  output  1  high while the request cannot complete this cycle.
REQ-009 proc_rdata  output  32  read data, valid when proc_read=1 and proc_stall=0.
REQ-010 mem_read  output  1  memory line-read request.
REQ-011 mem_write  output  1  memory line-write request.
REQ-012 mem_addr  output  28  line address {tag,index}.
REQ-013 mem_wdata  output  128  line write data, word0 in [31:0].
REQ-014 mem_rdata  input  128  line read data, word0 in [31:0].
REQ-015 mem_ready  input  1  one-cycle completion pulse for the current mem_read or mem_write.

Function
REQ-016 The per-line state SHALL be valid, dirty, 25-bit tag and 128-bit data.
REQ-017 The FSM states SHALL be COMPARE, WRITEBACK and ALLOCATE.
REQ-018 In COMPARE, hit SHALL mean valid=1 and stored tag = proc_addr[29:5] at index proc_addr[4:2].
REQ-019 COMPARE with no request SHALL hold proc_stall=0 and issue no memory traffic.
REQ-020 A read hit SHALL drive proc_stall=0 combinationally in the same cycle and drive proc_rdata = addressed word, for 0-cycle hit latency.
REQ-021 A write hit SHALL drive proc_stall=0 in the same cycle and, at the clock edge, write proc_wdata into the addressed word and set dirty=1.
REQ-022 A miss SHALL drive proc_stall=1 in the same cycle.
- Next state SHALL be WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-023 WRITEBACK SHALL hold mem_write=1, mem_addr={victim tag,index} and mem_wdata=victim line until mem_ready=1.
- On that edge the FSM SHALL go to ALLOCATE.
REQ-024 ALLOCATE SHALL hold mem_read=1 and mem_addr={proc_addr[29:5],index} until mem_ready=1.
- On that edge the line SHALL load mem_rdata, set tag, valid=1, dirty=0, and return to COMPARE.
REQ-025 proc_stall SHALL be 1 in every WRITEBACK and ALLOCATE cycle.
- The request completes as a hit in the COMPARE cycle following refill.
- A write miss therefore merges and sets dirty there.
REQ-026 mem_read and mem_write SHALL be decoded from state only, never both high, and 0 in COMPARE.
REQ-027 Processor request inputs SHALL be held stable by the master while proc_stall=1; the cache is not required to tolerate changes.
REQ-028 If proc_read and proc_write are both 1, the request SHALL be treated as a write.
REQ-029 If mem_ready stays 0, the cache SHALL remain in WRITEBACK or ALLOCATE with outputs unchanged indefinitely.
REQ-030 mem_ready sampled in COMPARE SHALL be ignored.
REQ-031 When not a read hit, proc_rdata SHALL still drive the addressed word of the indexed line; it is don't-care to the master.

Reset
REQ-032 On a clock edge with rst=1, the cache SHALL enter COMPARE and clear all valid and dirty bits.
- Tag and data contents need not be cleared.
REQ-033 During and immediately after reset, mem_read=0 and mem_write=0.
- proc_stall SHALL be 0 unless a request is present, which then misses.
REQ-034 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abandon the memory transaction with no line update.

Verification
REQ-035 Cold read: reset, then read proc_addr=30'h5 with mem_ready after 3 cycles and mem_rdata word1=32'hDEADBEEF.
- Required: mem_read=1 with mem_addr=28'h1, no mem_write, stall high 4 cycles, then stall=0 and proc_rdata=32'hDEADBEEF.
REQ-036 Write hit: after REQ-035, write proc_addr=30'h5 with data 32'h12345678.
- Required: stall=0 the same cycle, no memory traffic; a following read of 30'h5 returns 32'h12345678.
REQ-037 Dirty eviction: after REQ-036, read proc_addr=30'h25.
- Required: mem_write with mem_addr=28'h1 and mem_wdata[63:32]=32'h12345678, then mem_read with mem_addr=28'h9, then hit.
REQ-038 Clean conflict: after REQ-037, read proc_addr=30'h5.
- Required: no mem_write; mem_read with mem_addr=28'h1.
REQ-039 Reset mid-miss: assert rst during WRITEBACK.
- Required: next cycle mem_write=0 and mem_read=0; a read of any previously cached address misses.
REQ-040 Stalled memory: hold mem_ready=0 for 50 cycles in ALLOCATE.
- Required: proc_stall, mem_read and mem_addr stay constant throughout, then complete normally on the pulse.
